// File: rtl/seq001_scan_ctrl_if.sv
// Parallel-side handshake bundle of the "001" scan controller: start/abort
// request, the word to scan, and the status/result outputs.
interface seq001_scan_ctrl_if #(
  parameter int W  = 8,
  parameter int CW = 4
);
  logic          start;
  logic          abort;
  logic [W-1:0]  data_in;
  logic          busy;
  logic          done;
  logic [CW-1:0] match_cnt;
  logic          det_mon;

  modport master (
    output start, abort, data_in,
    input  busy, done, match_cnt, det_mon
  );

  modport slave (
    input  start, abort, data_in,
    output busy, done, match_cnt, det_mon
  );
endinterface

// File: rtl/seq001_scan_ctrl.sv
// Serialises a captured word MSB first through a Moore "001" detector and
// reports the saturating count of overlapping detections per completed word.
module seq001_scan_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq001_scan_ctrl_if.slave  bus
);
  localparam int BW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  state_t        state;
  det_t          det;
  det_t          det_d;
  logic [W-1:0]  shreg;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] work_cnt;
  logic [CW-1:0] cnt_next;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] match_q;
  logic          det_mon_q;

  function automatic det_t det_next(input det_t s, input logic b);
    unique case (s)
      S0:      return b ? S0 : S1;
      S1:      return b ? S0 : S2;
      S2:      return b ? S3 : S2;
      default: return b ? S0 : S1;
    endcase
  endfunction

  // NOTE: pure continuous decode -- every path yields a value, so no latch.
  assign det_d    = det_next(det, shreg[W-1]);
  // The counter sticks at all-ones instead of wrapping.
  assign cnt_next = (det_mon_q && work_cnt != '1) ? work_cnt + CW'(1) : work_cnt;

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      det       <= S0;
      shreg     <= '0;
      bit_cnt   <= '0;
      work_cnt  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= '0;
      det_mon_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            shreg     <= bus.data_in;
            bit_cnt   <= '0;
            det       <= S0;
            det_mon_q <= 1'b0;
            work_cnt  <= '0;
            busy_q    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            det       <= det_d;
            det_mon_q <= (det_d == S3);
            shreg     <= {shreg[W-2:0], 1'b0};
            bit_cnt   <= bit_cnt + BW'(1);
            work_cnt  <= cnt_next;
            if (bit_cnt == BW'(W - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The detection produced by the last bit is only visible now.
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            work_cnt <= cnt_next;
            match_q  <= cnt_next;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.match_cnt = match_q;
  assign bus.det_mon   = det_mon_q;
endmodule

// File: tb/tb_seq001_scan_ctrl.sv
// Bench for seq001_scan_ctrl: a timeline model checked every cycle, plus
// directed scans with hand-computed counts, latencies and event cases.
module tb_seq001_scan_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  seq001_scan_ctrl_if #(.W(W), .CW(CW)) bus8 ();
  seq001_scan_ctrl_if #(.W(9), .CW(1))  bus9 ();

  seq001_scan_ctrl #(.W(W), .CW(CW)) dut   (.clk(clk), .rst(rst), .bus(bus8));
  seq001_scan_ctrl #(.W(9), .CW(1))  dut9  (.clk(clk), .rst(rst), .bus(bus9));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t counts edges since the accepted start edge (-1 when idle).
  // After edge t the word has consumed t bits; done shows after edge W+1.
  function automatic logic win(input logic [W-1:0] w, input int k);
    if (k < 2) return 1'b0;
    return !w[W-1-(k-2)] && !w[W-1-(k-1)] && w[W-1-k];
  endfunction

  function automatic int count001(input logic [W-1:0] w);
    int n = 0;
    for (int k = 2; k < W; k++) n += int'(win(w, k));
    return (n > 2**CW - 1) ? 2**CW - 1 : n;
  endfunction

  int            t;
  logic [W-1:0]  mword;
  logic          m_det, m_busy, m_done;
  logic [CW-1:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t <= -1; mword <= '0; m_det <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= '0;
    end else begin
      m_done <= 1'b0;
      if (t < 0) begin
        if (bus8.start) begin
          t <= 0; mword <= bus8.data_in; m_det <= 1'b0; m_busy <= 1'b1;
        end
      end else if (t <= W && bus8.abort) begin
        t <= -1; m_busy <= 1'b0;
      end else begin
        if (t + 1 <= W) m_det <= win(mword, t);
        if (t + 1 == W + 1) m_cnt <= CW'(count001(mword));
        m_done <= (t + 1 == W + 1);
        m_busy <= (t + 1 <= W + 1);
        t      <= (t + 1 == W + 2) ? -1 : t + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",      bus8.busy,      m_busy);
      check("done",      bus8.done,      m_done);
      check("match_cnt", bus8.match_cnt, m_cnt);
      check("det_mon",   bus8.det_mon,   m_det);
    end
  end

  // Start one word; i=0 is the negedge right after the start edge E0.
  task automatic scan(input logic [W-1:0] w, input logic ab0, input int exp_cnt);
    int busy_cycles = 0;
    int done_at = -1;
    @(negedge clk);
    bus8.start = 1'b1; bus8.abort = ab0; bus8.data_in = w;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus8.start = 1'b0; bus8.abort = 1'b0;
      if (bus8.busy) busy_cycles++;
      if (bus8.done && done_at < 0) done_at = i;
    end
    check("scan_cnt",    bus8.match_cnt, exp_cnt);
    check("busy_cycles", busy_cycles,    W + 2);
    check("done_lat",    done_at,        W + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dones;
    int done_at;
    bus8.start = 1'b0; bus8.abort = 1'b0; bus8.data_in = '0;
    bus9.start = 1'b0; bus9.abort = 1'b0; bus9.data_in = '0;
    #2 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",    bus8.busy,      0);
    check("rst_done",    bus8.done,      0);
    check("rst_cnt",     bus8.match_cnt, 0);
    check("rst_det_mon", bus8.det_mon,   0);
    rst = 1'b0;

    scan(8'b00100100, 1'b0, 2);
    scan(8'b11111111, 1'b0, 0);
    scan(8'b00000001, 1'b1, 1);   // start+abort together in IDLE: start wins
    check("det_mon_hold", bus8.det_mon, 1);
    scan(8'b00000000, 1'b0, 0);
    scan(8'b10000000, 1'b0, 0);

    // Stray starts during SHIFT (E4) and the DONE cycle (E10) are ignored.
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus8.done) dones++;
      bus8.start   = (i == 0 || i == 4 || i == 10);
      bus8.data_in = (i == 0) ? 8'b00100100 : 8'b11111111;
    end
    bus8.start = 1'b0;
    check("stray_dones", dones, 1);
    check("stray_cnt",   bus8.match_cnt, 2);

    // Abort at the 4th SHIFT cycle (sampled at E4).
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.done) dones++;
      if (i == 6) check("abort_idle", bus8.busy, 0);
      bus8.start   = (i == 0);
      bus8.abort   = (i == 4 || i == 10);
      bus8.data_in = 8'b00100100;
    end
    bus8.abort = 1'b0;
    check("abort_dones", dones, 0);
    check("abort_cnt",   bus8.match_cnt, 2);

    // Reset in the middle of SHIFT clears every output at once.
    @(negedge clk);
    bus8.start = 1'b1; bus8.data_in = 8'b00100100;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",    bus8.busy,      0);
    check("mid_rst_done",    bus8.done,      0);
    check("mid_rst_cnt",     bus8.match_cnt, 0);
    check("mid_rst_det_mon", bus8.det_mon,   0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // W=9, CW=1: three detections saturate at 1, done after W+1 = 10 edges.
    check("w9_rst_cnt", bus9.match_cnt, 0);
    done_at = -1;
    @(negedge clk);
    bus9.start = 1'b1; bus9.data_in = 9'b001001001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus9.start = 1'b0;
      if (bus9.done && done_at < 0) done_at = i;
    end
    check("w9_done_lat", done_at, 10);
    check("w9_sat_cnt",  bus9.match_cnt, 1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
